// File: rtl/bitstream_halfbuf_feeder.sv
// Packs valid/ready bitstream bytes big-endian into 16-bit words and writes one
// RAM half-buffer per START_I edge. Optional end-of-stream zero padding: BITFEED_EOS_PAD_EN.
module bitstream_halfbuf_feeder #(
  parameter int ADDR_W     = 10,
  parameter int FIRST_HALF = 0
) (
  input  logic              CLK_I,
  input  logic              RESET_I,
  input  logic              START_I,
  input  logic [7:0]        BYTE_I,
  input  logic              BYTE_VALID_I,
`ifdef BITFEED_EOS_PAD_EN
  input  logic              EOS_I,
`endif
  output logic              BYTE_READY_O,
  output logic [ADDR_W-1:0] ADDRESS_O,
  output logic [15:0]       DATA_O,
  output logic              WE_O,
  output logic              EN_O,
  output logic              DONE_O,
  output logic              BUSY_O
);

  typedef enum logic [2:0] {ST_IDLE, ST_GET_HI, ST_GET_LO, ST_WRITE, ST_DONE} state_t;

  state_t            state_q;
  logic              start_q;
  logic              pending_q;
  logic              half_q;
  logic [ADDR_W-2:0] offset_q;
  logic [7:0]        hi_q;
  logic              ready_q;
  logic              we_q;
  logic              done_q;
  logic              busy_q;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       data_q;
`ifdef BITFEED_EOS_PAD_EN
  logic              pad_q;
`endif

  logic start_edge;
  assign start_edge = START_I & ~start_q;

  // Outputs are registered: each transition sets the outputs of the state being entered.
  always_ff @(posedge CLK_I) begin
    if (RESET_I) begin
      state_q   <= ST_IDLE;
      start_q   <= 1'b0;
      pending_q <= 1'b0;
      half_q    <= 1'(FIRST_HALF);
      offset_q  <= '0;
      hi_q      <= '0;
      ready_q   <= 1'b0;
      we_q      <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
`ifdef BITFEED_EOS_PAD_EN
      pad_q     <= 1'b0;
`endif
    end else begin
      start_q <= START_I;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      if (start_edge && state_q != ST_IDLE) pending_q <= 1'b1;

      case (state_q)
        ST_IDLE: begin
          if (start_edge || pending_q) begin
            pending_q <= 1'b0;
            busy_q    <= 1'b1;
`ifdef BITFEED_EOS_PAD_EN
            if (pad_q) begin
              state_q <= ST_WRITE;
              we_q    <= 1'b1;
              addr_q  <= {half_q, offset_q};
              data_q  <= '0;
            end else begin
`else
            begin
`endif
              state_q <= ST_GET_HI;
              ready_q <= 1'b1;
            end
          end
        end
        ST_GET_HI: begin
          if (BYTE_VALID_I) begin
            hi_q    <= BYTE_I;
            state_q <= ST_GET_LO;
          end
`ifdef BITFEED_EOS_PAD_EN
          else if (EOS_I) begin
            pad_q   <= 1'b1;
            ready_q <= 1'b0;
            state_q <= ST_WRITE;
            we_q    <= 1'b1;
            addr_q  <= {half_q, offset_q};
            data_q  <= '0;
          end
`endif
        end
        ST_GET_LO: begin
          if (BYTE_VALID_I) begin
            ready_q <= 1'b0;
            state_q <= ST_WRITE;
            we_q    <= 1'b1;
            addr_q  <= {half_q, offset_q};
            data_q  <= {hi_q, BYTE_I};
          end
`ifdef BITFEED_EOS_PAD_EN
          else if (EOS_I) begin
            pad_q   <= 1'b1;
            ready_q <= 1'b0;
            state_q <= ST_WRITE;
            we_q    <= 1'b1;
            addr_q  <= {half_q, offset_q};
            data_q  <= {hi_q, 8'h00};
          end
`endif
        end
        ST_WRITE: begin
          if (&offset_q) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end else begin
            offset_q <= offset_q + 1'b1;
`ifdef BITFEED_EOS_PAD_EN
            if (pad_q) begin
              we_q   <= 1'b1;
              addr_q <= {half_q, offset_q + 1'b1};
              data_q <= '0;
            end else begin
`else
            begin
`endif
              state_q <= ST_GET_HI;
              ready_q <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          half_q   <= ~half_q;
          offset_q <= '0;
          busy_q   <= 1'b0;
          state_q  <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign BYTE_READY_O = ready_q;
  assign ADDRESS_O    = addr_q;
  assign DATA_O       = data_q;
  assign WE_O         = we_q;
  assign EN_O         = we_q;
  assign DONE_O       = done_q;
  assign BUSY_O       = busy_q;

endmodule

// File: tb/tb_bitstream_halfbuf_feeder.sv
// Scoreboard bench for bitstream_halfbuf_feeder: a byte-stream model predicts
// every RAM write per fill request; a negedge monitor pops and compares.
module tb_bitstream_halfbuf_feeder;

  logic        CLK_I = 1'b0;
  logic        RESET_I;
  logic        START_I;
  logic [7:0]  BYTE_I;
  logic        BYTE_VALID_I;
`ifdef BITFEED_EOS_PAD_EN
  logic        EOS_I;
`endif
  logic        BYTE_READY_O;
  logic [9:0]  ADDRESS_O;
  logic [15:0] DATA_O;
  logic        WE_O, EN_O, DONE_O, BUSY_O;

  bitstream_halfbuf_feeder #(.ADDR_W(10), .FIRST_HALF(0)) dut (
    .CLK_I(CLK_I), .RESET_I(RESET_I), .START_I(START_I),
    .BYTE_I(BYTE_I), .BYTE_VALID_I(BYTE_VALID_I),
`ifdef BITFEED_EOS_PAD_EN
    .EOS_I(EOS_I),
`endif
    .BYTE_READY_O(BYTE_READY_O), .ADDRESS_O(ADDRESS_O), .DATA_O(DATA_O),
    .WE_O(WE_O), .EN_O(EN_O), .DONE_O(DONE_O), .BUSY_O(BUSY_O)
  );

  always #5 CLK_I = ~CLK_I;

  int checks = 0, failures = 0;
  int cyc = 0, wr_in_fill = 0, done_cyc = 0, busy_start = 0, busy_len = 0, gap = 0, t0 = 0;
  logic busy_prev = 1'b0;
  logic drv_en = 1'b1, rand_valid = 1'b0;

  // Reference model: byte stream i -> value i mod 256, word w = {byte 2w, byte 2w+1}
  int unsigned half_m = 0, wc = 0;
  logic [9:0]  exp_addr[$];
  logic [15:0] exp_data[$];
  int          exp_done_n = 0;

  function automatic void push_fill();
    for (int k = 0; k < 512; k++) begin
      exp_addr.push_back(10'(half_m * 512 + k));
      exp_data.push_back({8'(2 * wc), 8'(2 * wc + 1)});
      wc++;
    end
    half_m ^= 1;
    exp_done_n++;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return 32'({BYTE_READY_O, ADDRESS_O, DATA_O, WE_O, EN_O, DONE_O, BUSY_O});
  endfunction

  // Byte source
  initial begin
    int unsigned idx = 0;
    logic hs, rs;
    BYTE_I = '0;
    BYTE_VALID_I = 1'b0;
    forever begin
      @(negedge CLK_I);
      hs = BYTE_VALID_I & BYTE_READY_O;
      rs = RESET_I;
      @(posedge CLK_I);
      #1;
      if (drv_en) begin
        if (rs) idx = 0;
        else if (hs) idx++;
        BYTE_I = 8'(idx);
        BYTE_VALID_I = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
      end
    end
  end

  // Monitor
  initial begin
    logic [9:0]  ea;
    logic [15:0] ed;
    forever begin
      @(negedge CLK_I);
      cyc++;
      chk("en_eq_we", 32'(EN_O), 32'(WE_O));
      if (BYTE_READY_O) chk("ready_phase", 32'({WE_O, DONE_O, BUSY_O}), 32'h1);
      if (BUSY_O && !busy_prev) begin
        busy_start = cyc;
        gap = cyc - done_cyc;
      end
      busy_prev = BUSY_O;
      if (WE_O) begin
        if (exp_addr.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write actual addr=%0d data=%h required=no write", ADDRESS_O, DATA_O);
        end else begin
          ea = exp_addr.pop_front();
          ed = exp_data.pop_front();
          chk("wr_addr", 32'(ADDRESS_O), 32'(ea));
          chk("wr_data", 32'(DATA_O), 32'(ed));
        end
        wr_in_fill++;
      end
      if (DONE_O) begin
        if (exp_done_n == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done actual=1 required=0");
        end else begin
          exp_done_n--;
          chk("words_per_fill", 32'(wr_in_fill), 32'd512);
        end
        wr_in_fill = 0;
        done_cyc = cyc;
        busy_len = cyc - busy_start + 1;
      end
    end
  end

  task automatic pulse_start();
    @(posedge CLK_I);
    #1 START_I = 1'b1;
    t0 = cyc;
    @(posedge CLK_I);
    #1 START_I = 1'b0;
  endtask

  task automatic drain(input int budget);
    int k = 0;
    while ((exp_done_n != 0 || exp_addr.size() != 0) && k < budget) begin
      @(negedge CLK_I);
      k++;
    end
    chk("drain_complete", 32'(k < budget), 32'd1);
  endtask

  task automatic wait_words(input int n);
    int k = 0;
    while (wr_in_fill < n && k < 4000) begin
      @(negedge CLK_I);
      k++;
    end
    chk("wait_words", 32'(wr_in_fill >= n), 32'd1);
  endtask

`ifdef BITFEED_EOS_PAD_EN
  task automatic send(input logic [7:0] b);
    int k = 0;
    BYTE_I = b;
    BYTE_VALID_I = 1'b1;
    @(negedge CLK_I);
    while (!BYTE_READY_O && k < 100) begin
      @(negedge CLK_I);
      k++;
    end
    chk("eos_byte_accept", 32'(BYTE_READY_O), 32'd1);
    @(posedge CLK_I);
    #1 BYTE_VALID_I = 1'b0;
  endtask
`endif

  initial begin
    RESET_I = 1'b1;
    START_I = 1'b0;
`ifdef BITFEED_EOS_PAD_EN
    EOS_I = 1'b0;
`endif
    repeat (3) @(posedge CLK_I);
    @(negedge CLK_I);
    chk("reset_outputs", outs(), 32'h0);
    @(posedge CLK_I);
    #1 RESET_I = 1'b0;

    // Level held 4 cycles counts once; timing of one full fill
    push_fill();
    START_I = 1'b1;
    t0 = cyc;
    repeat (4) @(posedge CLK_I);
    #1 START_I = 1'b0;
    drain(2000);
    chk("s1_start_to_done", 32'(done_cyc - t0), 32'd1538);
    chk("s1_busy_len", 32'(busy_len), 32'd1537);
    repeat (20) @(posedge CLK_I);

    // Alternating halves
    for (int f = 0; f < 2; f++) begin
      push_fill();
      pulse_start();
      drain(2000);
      chk("s2_start_to_done", 32'(done_cyc - t0), 32'd1538);
      chk("s2_busy_len", 32'(busy_len), 32'd1537);
    end

    // Edges while busy: one pending fill, a second edge is dropped
    push_fill();
    pulse_start();
    wait_words(50);
    push_fill();
    pulse_start();
    wait_words(200);
    pulse_start();
    drain(4000);
    chk("s3_gap", 32'(gap), 32'd2);
    chk("s3_busy_len", 32'(busy_len), 32'd1537);
    repeat (20) @(posedge CLK_I);
    chk("s3_no_extra_fill", 32'(exp_addr.size() + exp_done_n), 32'd0);

    // Random source stalls
    rand_valid = 1'b1;
    push_fill();
    pulse_start();
    drain(8000);
    rand_valid = 1'b0;

    // Reset mid-fill
    push_fill();
    pulse_start();
    wait_words(100);
    @(posedge CLK_I);
    #1 RESET_I = 1'b1;
    @(posedge CLK_I);
    #1 RESET_I = 1'b0;
    exp_addr.delete();
    exp_data.delete();
    exp_done_n = 0;
    wr_in_fill = 0;
    half_m = 0;
    wc = 0;
    @(negedge CLK_I);
    chk("s5_reset_outputs", outs(), 32'h0);
    push_fill();
    pulse_start();
    drain(2000);

`ifdef BITFEED_EOS_PAD_EN
    drv_en = 1'b0;
    @(posedge CLK_I);
    #1 RESET_I = 1'b1;
    BYTE_VALID_I = 1'b0;
    @(posedge CLK_I);
    #1 RESET_I = 1'b0;
    wr_in_fill = 0;
    half_m = 0;
    for (int k = 0; k < 512; k++) begin
      exp_addr.push_back(10'(k));
      exp_data.push_back(k == 0 ? 16'hAABB : (k == 1 ? 16'hCC00 : 16'h0000));
    end
    exp_done_n++;
    pulse_start();
    send(8'hAA);
    send(8'hBB);
    send(8'hCC);
    EOS_I = 1'b1;
    drain(2000);
`endif

    repeat (10) @(posedge CLK_I);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
